vga_pixel_sink: RTL and testbench

- Receiving end of the pixel-write interface (X, Y, Colour, Plot) driven by the display/draw FSMs.
- Holds a 320x240x3-bit framebuffer that takes single-pixel writes from the draw side.
- Scans the framebuffer out continuously as 640x480@60 Hz VGA; each stored pixel is shown as a 2x2 block.
- Also provides hardware clear-to-background with a busy handshake, so draw FSMs can stop re-painting the full screen themselves.

---
 rtl/vga_pixel_sink.sv | 231 +++++++++++++++++++++++
 tb/tb_vga_pixel_sink.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_sink.sv
// Pixel-write sink: 3-bit framebuffer (quarter of the VGA resolution) with a
// single-pixel write port, a hardware clear-to-background engine with a busy
// flag, and continuous VGA scan-out showing each stored pixel as a 2x2 block.
module vga_pixel_sink #(
   parameter logic [2:0]  BACKGROUND = 3'b111,
   parameter int unsigned H_VIS      = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_VIS      = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33
) (
   input  logic       iClock,
   input  logic       iReset,
   input  logic [8:0] iX,
   input  logic [7:0] iY,
   input  logic [2:0] iColour,
   input  logic       iPlot,
   input  logic       iClear,
   output logic       oBusy,
   output logic       oFrameStart,
   output logic [7:0] oVGA_R,
   output logic [7:0] oVGA_G,
   output logic [7:0] oVGA_B,
   output logic       oVGA_HS,
   output logic       oVGA_VS,
   output logic       oVGA_BLANK_N,
   output logic       oVGA_SYNC_N,
   output logic       oVGA_CLK
);

   localparam int unsigned H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_SYNC_START = H_VIS + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_VIS + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam int unsigned FB_W         = H_VIS / 2;
   localparam int unsigned FB_H         = V_VIS / 2;
   localparam int unsigned FB_SIZE      = FB_W * FB_H;
   localparam int unsigned ADDR_W       = $clog2(FB_SIZE);
   localparam int unsigned HC_W         = $clog2(H_TOTAL);
   localparam int unsigned VC_W         = $clog2(V_TOTAL);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } clear_state_t;

   // Timing state
   logic            pix_en;
   logic [HC_W-1:0] hcount;
   logic [VC_W-1:0] vcount;

   // Counter-stage decode
   logic              h_vis;
   logic              v_vis;
   logic              vis_now;
   logic              hs_now;
   logic              vs_now;
   logic              fs_now;
   logic [ADDR_W-1:0] rd_addr;

   // Pipeline stage aligned with the RAM read
   logic       vis_d;
   logic       hs_d;
   logic       vs_d;
   logic       fs_d;
   logic [2:0] rd_data;

   // Clear engine and write port
   clear_state_t      clr_state;
   logic [ADDR_W-1:0] clr_addr;
   logic              plot_ok;
   logic [ADDR_W-1:0] plot_addr;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [2:0]        wdata;

   logic [2:0] fb [FB_SIZE];

   assign oVGA_SYNC_N = 1'b0;
   assign oVGA_CLK    = pix_en;

   // Pixel-clock enable: one pixel every two system clocks
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         pix_en <= 1'b0;
      end else begin
         pix_en <= ~pix_en;
      end
   end

   // Raster counters, advancing once per pixel clock
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         hcount <= '0;
         vcount <= '0;
      end else if (pix_en) begin
         if (hcount == HC_W'(H_TOTAL - 1)) begin
            hcount <= '0;
            if (vcount == VC_W'(V_TOTAL - 1)) begin
               vcount <= '0;
            end else begin
               vcount <= vcount + VC_W'(1);
            end
         end else begin
            hcount <= hcount + HC_W'(1);
         end
      end
   end

   // Decode sync/blank/frame-start and the read address from the raw counters
   always_comb begin
      h_vis   = 32'(hcount) < H_VIS;
      v_vis   = 32'(vcount) < V_VIS;
      vis_now = h_vis && v_vis;
      hs_now  = !((32'(hcount) >= H_SYNC_START) && (32'(hcount) < H_SYNC_END));
      vs_now  = !((32'(vcount) >= V_SYNC_START) && (32'(vcount) < V_SYNC_END));
      // Only the first system clock of position (0, V_VIS) so the pulse is one cycle wide
      fs_now  = !pix_en && (hcount == '0) && (32'(vcount) == V_VIS);
      rd_addr = '0;
      if (vis_now) begin
         rd_addr = ADDR_W'((32'(vcount) >> 1) * FB_W + (32'(hcount) >> 1));
      end
   end

   // Clear engine: sweeps the whole buffer with BACKGROUND, busy through DONE
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         clr_state <= ST_IDLE;
         clr_addr  <= '0;
         oBusy     <= 1'b0;
      end else begin
         case (clr_state)
            ST_IDLE: begin
               if (iClear) begin
                  clr_state <= ST_CLEAR;
                  clr_addr  <= '0;
                  oBusy     <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (clr_addr == ADDR_W'(FB_SIZE - 1)) begin
                  clr_state <= ST_DONE;
               end else begin
                  clr_addr <= clr_addr + ADDR_W'(1);
               end
            end
            ST_DONE: begin
               clr_state <= ST_IDLE;
               oBusy     <= 1'b0;
            end
            default: begin
               clr_state <= ST_IDLE;
               oBusy     <= 1'b0;
            end
         endcase
      end
   end

   // Write-port arbitration: clear sweep owns the port, plots only when idle and no clear request
   always_comb begin
      plot_ok   = iPlot && (32'(iX) < FB_W) && (32'(iY) < FB_H);
      plot_addr = ADDR_W'(32'(iY) * FB_W + 32'(iX));
      we        = 1'b0;
      waddr     = '0;
      wdata     = '0;
      if (clr_state == ST_CLEAR) begin
         we    = 1'b1;
         waddr = clr_addr;
         wdata = BACKGROUND;
      end else if ((clr_state == ST_IDLE) && !iClear && plot_ok) begin
         we    = 1'b1;
         waddr = plot_addr;
         wdata = iColour;
      end
   end

   // Framebuffer write port; contents survive reset
   always_ff @(posedge iClock) begin
      if (we) begin
         fb[waddr] <= wdata;
      end
   end

   // Framebuffer read port; a same-cycle write to this address is not visible yet
   always_ff @(posedge iClock) begin
      rd_data <= fb[rd_addr];
   end

   // Delay syncs/blank/frame-start by the RAM read latency
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         vis_d <= 1'b0;
         hs_d  <= 1'b1;
         vs_d  <= 1'b1;
         fs_d  <= 1'b0;
      end else begin
         vis_d <= vis_now;
         hs_d  <= hs_now;
         vs_d  <= vs_now;
         fs_d  <= fs_now;
      end
   end

   // Output register: colour expansion with blanking forcing black
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         oVGA_R       <= 8'h00;
         oVGA_G       <= 8'h00;
         oVGA_B       <= 8'h00;
         oVGA_HS      <= 1'b1;
         oVGA_VS      <= 1'b1;
         oVGA_BLANK_N <= 1'b0;
         oFrameStart  <= 1'b0;
      end else begin
         oVGA_R       <= vis_d ? {8{rd_data[2]}} : 8'h00;
         oVGA_G       <= vis_d ? {8{rd_data[1]}} : 8'h00;
         oVGA_B       <= vis_d ? {8{rd_data[0]}} : 8'h00;
         oVGA_HS      <= hs_d;
         oVGA_VS      <= vs_d;
         oVGA_BLANK_N <= vis_d;
         oFrameStart  <= fs_d;
      end
   end

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Bench for vga_pixel_sink on a shrunken raster (16x12 visible, 8x6 buffer)
// so several whole frames and complete clears fit in a short run.
module tb_vga_pixel_sink;

   localparam int unsigned H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 2;
   localparam int unsigned V_VIS = 12, V_FP = 1, V_SYNC = 2, V_BP = 1;
   localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int unsigned FB_W = H_VIS / 2, FB_H = V_VIS / 2;
   localparam int unsigned FB_SIZE = FB_W * FB_H;
   localparam int unsigned FRAME = H_TOT * V_TOT;
   localparam int unsigned FRAME_CYC = 2 * FRAME;
   localparam logic [2:0] BG = 3'b111;
   // {R,G,B,HS,VS,BLANK_N,SYNC_N,FRAME_START,VGA_CLK,BUSY}
   localparam logic [30:0] RESET_VEC = {24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   logic       iClock = 1'b0;
   logic       iReset = 1'b1;
   logic [8:0] iX = '0;
   logic [7:0] iY = '0;
   logic [2:0] iColour = '0;
   logic       iPlot = 1'b0;
   logic       iClear = 1'b0;
   logic       oBusy, oFrameStart, oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N, oVGA_CLK;
   logic [7:0] oVGA_R, oVGA_G, oVGA_B;

   vga_pixel_sink #(
      .BACKGROUND(BG),
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .iClock(iClock), .iReset(iReset), .iX(iX), .iY(iY), .iColour(iColour),
      .iPlot(iPlot), .iClear(iClear), .oBusy(oBusy), .oFrameStart(oFrameStart),
      .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B), .oVGA_HS(oVGA_HS),
      .oVGA_VS(oVGA_VS), .oVGA_BLANK_N(oVGA_BLANK_N), .oVGA_SYNC_N(oVGA_SYNC_N),
      .oVGA_CLK(oVGA_CLK)
   );

   always #5 iClock = ~iClock;

   // System-clock edges since reset release
   int unsigned k;
   always @(posedge iClock or posedge iReset) begin
      if (iReset) k <= 0;
      else        k <= k + 1;
   end

   logic [30:0] dut_vec;
   assign dut_vec = {oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK_N,
                     oVGA_SYNC_N, oFrameStart, oVGA_CLK, oBusy};

   logic [2:0] mfb [FB_SIZE];
   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      int unsigned x;
      int unsigned y;
      logic [2:0]  col;
      bit          accept;
   } plot_vec_t;

   typedef struct {
      int unsigned h;
      int unsigned v;
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
   } spot_vec_t;

   plot_vec_t pv [6];
   spot_vec_t sv [10];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, k);
      end
   endtask

   // Expected outputs after kk clock edges: pixel position (kk-2)/2 in raster order
   function automatic logic [30:0] model_out(input int unsigned kk);
      int unsigned p, h, v;
      logic [2:0] c;
      logic bn, hs, vs, fs;
      if (kk < 2) return {24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'(kk % 2), 1'b0};
      p  = ((kk - 2) / 2) % FRAME;
      h  = p % H_TOT;
      v  = p / H_TOT;
      bn = (h < H_VIS) && (v < V_VIS);
      hs = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
      vs = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
      fs = (((kk - 2) % 2) == 0) && (p == V_VIS * H_TOT);
      c  = 3'b000;
      if (bn) c = mfb[(v / 2) * FB_W + h / 2];
      return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}, hs, vs, bn, 1'b0, fs, 1'(kk % 2), 1'b0};
   endfunction

   task automatic check_frame(input string name, input int unsigned ncyc);
      for (int unsigned i = 0; i < ncyc; i++) begin
         @(negedge iClock);
         check(name, 64'(dut_vec), 64'(model_out(k)));
      end
   endtask

   task automatic fill_bg();
      for (int unsigned a = 0; a < FB_SIZE; a++) mfb[a] = BG;
   endtask

   task automatic wait_pos(input int unsigned h, input int unsigned v, output bit found);
      found = 1'b0;
      for (int unsigned i = 0; i < FRAME_CYC + 8 && !found; i++) begin
         @(negedge iClock);
         if (k >= 2 && ((k - 2) % 2) == 0 && (((k - 2) / 2) % FRAME) == v * H_TOT + h)
            found = 1'b1;
      end
   endtask

   // Count consecutive busy samples (including the current one) while plotting in-range junk
   task automatic count_busy(input bit plot_junk, output int unsigned cnt);
      cnt = 1;
      for (int unsigned i = 0; i < FB_SIZE + 20 && oBusy; i++) begin
         iPlot   = plot_junk;
         iX      = 9'($urandom_range(0, FB_W - 1));
         iY      = 8'($urandom_range(0, FB_H - 1));
         iColour = 3'($urandom_range(0, 6));
         @(negedge iClock);
         if (oBusy) cnt++;
      end
      iPlot = 1'b0;
   endtask

   initial begin
      int unsigned cnt;
      bit found;

      pv[0] = '{0, 0, 3'b100, 1'b1};
      pv[1] = '{7, 5, 3'b001, 1'b1};
      pv[2] = '{8, 3, 3'b010, 1'b0};
      pv[3] = '{2, 6, 3'b011, 1'b0};
      pv[4] = '{300, 2, 3'b000, 1'b0};
      pv[5] = '{3, 2, 3'b110, 1'b1};

      sv[0] = '{0, 0, 8'hFF, 8'h00, 8'h00};
      sv[1] = '{1, 0, 8'hFF, 8'h00, 8'h00};
      sv[2] = '{2, 0, 8'hFF, 8'hFF, 8'hFF};
      sv[3] = '{17, 0, 8'h00, 8'h00, 8'h00};
      sv[4] = '{0, 1, 8'hFF, 8'h00, 8'h00};
      sv[5] = '{1, 1, 8'hFF, 8'h00, 8'h00};
      sv[6] = '{6, 4, 8'hFF, 8'hFF, 8'h00};
      sv[7] = '{14, 10, 8'h00, 8'h00, 8'hFF};
      sv[8] = '{13, 11, 8'hFF, 8'hFF, 8'hFF};
      sv[9] = '{15, 11, 8'h00, 8'h00, 8'hFF};

      // Reset values
      #23;
      check("reset_outputs", 64'(dut_vec), 64'(RESET_VEC));
      @(negedge iClock);
      iReset = 1'b0;

      // Clear and plot in the same cycle: clear wins; plots during busy dropped
      @(negedge iClock);
      iClear = 1'b1; iPlot = 1'b1; iX = 9'd1; iY = 8'd1; iColour = 3'b000;
      @(negedge iClock);
      iClear = 1'b0;
      check("busy_rise", 64'(oBusy), 64'(1));
      count_busy(1'b1, cnt);
      check("busy_length", 64'(cnt), 64'(FB_SIZE + 1));
      fill_bg();
      repeat (2) @(negedge iClock);
      check_frame("clear_frame", FRAME_CYC + 4);

      // Table of single plots, each followed by a full-frame compare
      for (int i = 0; i < 6; i++) begin
         @(negedge iClock);
         iPlot = 1'b1; iX = 9'(pv[i].x); iY = 8'(pv[i].y); iColour = pv[i].col;
         @(negedge iClock);
         iPlot = 1'b0;
         if (pv[i].accept) mfb[pv[i].y * FB_W + pv[i].x] = pv[i].col;
         repeat (2) @(negedge iClock);
         check_frame("plot_table_frame", FRAME_CYC);
      end

      // Spot checks of 2x2 expansion, corners and blanking
      for (int i = 0; i < 10; i++) begin
         wait_pos(sv[i].h, sv[i].v, found);
         check("spot_found", 64'(found), 64'(1));
         check("spot_r", 64'(oVGA_R), 64'(sv[i].r));
         check("spot_g", 64'(oVGA_G), 64'(sv[i].g));
         check("spot_b", 64'(oVGA_B), 64'(sv[i].b));
      end

      // Random plots with partly out-of-range coordinates
      for (int i = 0; i < 300; i++) begin
         @(negedge iClock);
         iPlot   = 1'($urandom_range(0, 1));
         iX      = 9'($urandom_range(0, 11));
         iY      = 8'($urandom_range(0, 8));
         iColour = 3'($urandom_range(0, 7));
         if (iPlot && (32'(iX) < FB_W) && (32'(iY) < FB_H))
            mfb[32'(iY) * FB_W + 32'(iX)] = iColour;
      end
      @(negedge iClock);
      iPlot = 1'b0;
      repeat (2) @(negedge iClock);
      check_frame("random_frame", FRAME_CYC);

      // Level-held clear restarts after the one-cycle DONE gap
      @(negedge iClock);
      iClear = 1'b1;
      @(negedge iClock);
      check("busy_level_rise", 64'(oBusy), 64'(1));
      count_busy(1'b0, cnt);
      check("busy_level_length", 64'(cnt), 64'(FB_SIZE + 1));
      check("busy_gap", 64'(oBusy), 64'(0));
      @(negedge iClock);
      check("busy_restart", 64'(oBusy), 64'(1));
      iClear = 1'b0;
      count_busy(1'b1, cnt);
      check("busy_restart_length", 64'(cnt), 64'(FB_SIZE + 1));
      fill_bg();
      repeat (2) @(negedge iClock);
      check_frame("level_clear_frame", FRAME_CYC);

      // Fill a non-background pattern, then reset partway through a clear
      for (int unsigned a = 0; a < FB_SIZE; a++) begin
         @(negedge iClock);
         iPlot = 1'b1; iX = 9'(a % FB_W); iY = 8'(a / FB_W); iColour = 3'(a % 7);
         mfb[a] = 3'(a % 7);
      end
      @(negedge iClock);
      iPlot = 1'b0;
      repeat (2) @(negedge iClock);
      check_frame("pattern_frame", FRAME_CYC);
      @(negedge iClock);
      iClear = 1'b1;
      @(negedge iClock);
      iClear = 1'b0;
      repeat (20) @(negedge iClock);
      iReset = 1'b1;
      #1;
      check("reset_mid_clear_busy", 64'(oBusy), 64'(0));
      check("reset_mid_clear_outputs", 64'(dut_vec), 64'(RESET_VEC));
      for (int unsigned a = 0; a < 20; a++) mfb[a] = BG;
      @(negedge iClock);
      iReset = 1'b0;
      check_frame("after_reset_frame", FRAME_CYC + 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", k);
      $fatal(1);
   end

endmodule
